// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues PC-tagged word fetches and buffers in-order responses for the ID stage.
// Optional performance counters are compiled in when IFETCH_QUEUE_PERF_EN is defined.
`timescale 1ns/1ps

module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_incr,
    input  logic        id_ready
`ifdef IFETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_drop_count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [31:0]    fetch_pc;
    logic [31:0]    slot_pc    [DEPTH];
    logic [31:0]    slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [PW-1:0]  head;
    logic [PW-1:0]  fill;
    logic [PW-1:0]  issue;
    logic [CW-1:0]  alloc_cnt;
    logic [CW-1:0]  pend_cnt;
    logic [CW-1:0]  drop_cnt;

    logic           fire;
    logic           pop;
    logic           rsp_drop;
    logic           rsp_fill;
    logic           head_valid;
    logic [CW-1:0]  token_cnt;
    logic [CW-1:0]  stale_cnt;
    logic [CW-1:0]  redirect_drop;
    logic [31:0]    redirect_aligned;

    // alloc+drop and pend+drop never exceed DEPTH, so CW bits hold both sums
    assign token_cnt = alloc_cnt + drop_cnt;
    assign stale_cnt = pend_cnt + drop_cnt;

    assign imem_req  = !rst && !redirect && (alloc_cnt < DEPTH_C) && (token_cnt < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    assign rsp_drop  = imem_rvalid && (drop_cnt != '0);
    assign rsp_fill  = imem_rvalid && (drop_cnt == '0) && (pend_cnt != '0);

    assign head_valid = slot_filled[head] && (alloc_cnt != '0);
    assign if_valid   = head_valid;
    assign if_instr   = head_valid ? slot_instr[head] : 32'd0;
    assign if_pc_incr = head_valid ? (slot_pc[head] + 32'd4) : 32'd0;
    assign pop        = head_valid && id_ready && !redirect;

    // a response landing in the redirect cycle retires one stale token immediately
    assign redirect_drop    = stale_cnt - ((imem_rvalid && (stale_cnt != '0)) ? CNT_ONE : '0);
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            fill        <= '0;
            issue       <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            drop_cnt    <= '0;
            slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc    <= redirect_aligned;
            head        <= '0;
            fill        <= '0;
            issue       <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            drop_cnt    <= redirect_drop;
            slot_filled <= '0;
        end else begin
            if (fire) begin
                fetch_pc           <= fetch_pc + 32'd4;
                issue              <= issue + PTR_ONE;
                slot_pc[issue]     <= fetch_pc;
                slot_filled[issue] <= 1'b0;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_ONE;
            end
            if (rsp_fill) begin
                fill              <= fill + PTR_ONE;
                slot_instr[fill]  <= imem_rdata;
                slot_filled[fill] <= 1'b1;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            alloc_cnt <= alloc_cnt + (fire ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
            pend_cnt  <= pend_cnt + (fire ? CNT_ONE : '0) - (rsp_fill ? CNT_ONE : '0);
        end
    end

`ifdef IFETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
            perf_drop_count   <= '0;
        end else begin
            if (!head_valid && !redirect) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
            if (imem_rvalid && (redirect || (drop_cnt != '0))) begin
                perf_drop_count <= perf_drop_count + 32'd1;
            end
        end
    end
`endif

endmodule
